icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-cache responder serving the fetch interface: Fetch1 issues idx/op/pa/is_cached, and Fetch2 consumes ready/data.
- 2-way set-associative, blocking, virtually-indexed/physically-tagged.
- On a miss it refills one line from memory through a burst read port.
- Uncached fetches bypass the arrays with a single-word read.

Parameters:
- SETS, 256, number of sets; idx width IW = $clog2(SETS).
- LINE_WORDS, 4, 32-bit words per line; offset width OW = $clog2(LINE_WORDS)+2.
- TAG_W, 32-IW-OW, physical tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- icache_idx  in  IW  set index, valid with icache_op.
- icache_op  in  2  0=NOP, 1=FETCH, 2=IDX_INV (invalidate both ways of set).
- icache_pa  in  32  physical address, same cycle as op.
- icache_is_cached  in  1  1 = cacheable.
- icache_accept  out  1  request in the current cycle is taken.
- icache_cancel  in  1  flush: drop the pending response.
- icache_ready  out  1  response valid, one-cycle pulse.
- icache_data  out  32  fetched instruction.
- mem_rd_req  out  1  read request, held until mem_rd_gnt.
- mem_rd_addr  out  32  line-aligned (cached) or word address (uncached).
- mem_rd_len  out  8  beats minus 1: LINE_WORDS-1 or 0.
- mem_rd_gnt  in  1  request handshake.
- mem_rd_valid  in  1  data beat valid.
- mem_rd_data  in  32  beat data.
- mem_rd_last  in  1  final beat.

Behaviour:
- Reset values: all valid bits 0; LRU bits 0; state IDLE; icache_ready 0; icache_data 0; mem_rd_req 0; icache_accept 1.
- icache_accept = (state==IDLE) || (state==LOOKUP && response completes this cycle) || (state==RESP).
- A request is taken when icache_accept && op!=NOP. Its pa, is_cached and op are registered. icache_idx must equal pa[IW+OW-1:OW].
- Array read is indexed by icache_idx in the accept cycle, so tag compare happens in the following cycle.
- States:
  - IDLE: request taken -> LOOKUP.
  - LOOKUP:
    - IDX_INV: clear both valids of the set; ready=1, data=0 -> IDLE, or take a new request.
    - Cached hit: ready=1, data = word pa[OW-1:2] of the hit way; LRU[set] = other way; stay in LOOKUP if a new request is taken, else IDLE.
    - Cached miss -> MISS_REQ.
    - Uncached -> UC_REQ. An uncached access never consults or modifies the arrays, even on a tag match.
  - MISS_REQ: mem_rd_req=1, addr = {pa[31:OW], 0}, len = LINE_WORDS-1; on gnt -> REFILL.
  - REFILL: each beat is written to the victim way, word counter 0..LINE_WORDS-1. Victim = an invalid way (way0 first), else LRU[set]. On mem_rd_last: set valid and tag, LRU[set] = other way -> RESP.
  - UC_REQ: addr = {pa[31:2], 2'b0}, len = 0; on gnt -> UC_WAIT.
  - UC_WAIT: capture data on valid&&last -> RESP.
  - RESP: ready=1 with the requested word (critical word taken from the refilled line or the uncached beat); accept new request -> LOOKUP, else IDLE.
- Cancel:
  - Cancel in LOOKUP suppresses ready; state returns to IDLE. Cancel has no effect on a request taken in the same cycle.
  - Cancel in MISS_REQ/REFILL/UC_*: set a sticky drop flag. The memory transaction always completes and the line is still installed. RESP then gives ready=0, the flag clears -> IDLE.
- Fetch must hold its request while accept=0.
- Beat-count mismatch (last before LINE_WORDS beats) is not supported.
- mem_rd_valid outside REFILL/UC_WAIT is ignored.
- Asynchronous reset mid-refill returns to IDLE and drops the transaction. Memory must also be reset.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0], reset to 0. They increment on cached hit and cached miss in LOOKUP respectively; cancelled lookups are not counted; counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared cpu_defs package:
  - icache_op_t enum (NOP/FETCH/IDX_INV).
  - icache_state_t enum.
  - ICACHE_SETS and ICACHE_LINE_WORDS constants.
  - mem_rd_req_t struct (req, addr, len).
- One natural sub-module: icache_way, holding the valid/tag/data arrays of one way with read and write ports; instantiated twice.
- LRU bits and FSM stay in the top.

Test Plan:
- Cold miss then hit:
  - FETCH pa 0x1C000008 cached -> mem_rd_addr 0x1C000000, len 3.
  - Beats 0xA0,0xA1,0xA2,0xA3 -> ready the cycle after last, data 0xA2.
  - FETCH 0x1C00000C -> ready next cycle, data 0xA3, no mem_rd_req.
- Uncached: FETCH 0x1FD00004 is_cached=0 -> addr 0x1FD00004, len 0, beat 0x55 -> data 0x55. Repeating the fetch issues mem_rd_req again.
- Eviction:
  - Fill 0x1C000000 and 0x1C001000 (same set 0).
  - Hit 0x1C000000.
  - Fetch 0x1C002000 -> replaces way holding 0x1C001000; 0x1C000000 still hits.
- Cancel mid-refill: assert cancel on 2nd beat -> no ready pulse, state IDLE after last beat. Refetch same pa -> hit in 1 cycle.
- IDX_INV: after filling 0x1C000000, IDX_INV idx 0 -> ready, data 0. Fetch 0x1C000000 -> miss, mem_rd_req.
- Reset: rst asserted during REFILL -> mem_rd_req 0, ready 0. A prior-hit address now misses.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared fetch-side definitions: opcodes, responder states, geometry constants
// and the memory read-request bundle.
package cpu_defs;

    localparam int ICACHE_SETS       = 256;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_FETCH   = 2'd1,
        OP_IDX_INV = 2'd2
    } icache_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_UC_REQ,
        ST_UC_WAIT,
        ST_RESP
    } icache_state_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [7:0]  len;
    } mem_rd_req_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side request/response bus and burst memory read bus of the I-cache.
// master = initiator of requests on each bus.
interface icache_fetch_if #(
    parameter int SETS = cpu_defs::ICACHE_SETS
);
    localparam int IW = $clog2(SETS);

    logic [IW-1:0] icache_idx;
    logic [1:0]    icache_op;
    logic [31:0]   icache_pa;
    logic          icache_is_cached;
    logic          icache_accept;
    logic          icache_cancel;
    logic          icache_ready;
    logic [31:0]   icache_data;

    modport master (
        output icache_idx, icache_op, icache_pa, icache_is_cached, icache_cancel,
        input  icache_accept, icache_ready, icache_data
    );

    modport slave (
        input  icache_idx, icache_op, icache_pa, icache_is_cached, icache_cancel,
        output icache_accept, icache_ready, icache_data
    );
endinterface

interface mem_rd_if;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_last;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_rd_len,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data, mem_rd_last
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_rd_len,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data, mem_rd_last
    );
endinterface

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits (flops, read combinationally so
// same-cycle invalidates are seen), plus tag and line arrays with registered read.
module icache_way
    import cpu_defs::*;
#(
    parameter  int SETS       = ICACHE_SETS,
    parameter  int LINE_WORDS = ICACHE_LINE_WORDS,
    localparam int IW         = $clog2(SETS),
    localparam int WW         = $clog2(LINE_WORDS),
    localparam int TAG_W      = 32 - IW - WW - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [IW-1:0]               rd_idx,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [LINE_WORDS-1:0][31:0] rd_line,
    input  logic [IW-1:0]               chk_idx,
    output logic                        chk_valid,
    input  logic                        inv,
    input  logic                        wr_en,
    input  logic [IW-1:0]               wr_idx,
    input  logic [WW-1:0]               wr_word,
    input  logic [31:0]                 wr_data,
    input  logic                        tag_wr,
    input  logic [TAG_W-1:0]            wr_tag
);

    logic [SETS-1:0]             valid;
    logic [TAG_W-1:0]            tag_mem  [SETS];
    logic [LINE_WORDS-1:0][31:0] data_mem [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inv)
                valid[chk_idx] <= 1'b0;
            if (tag_wr)
                valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[wr_idx][wr_word] <= wr_data;
        if (tag_wr)
            tag_mem[wr_idx] <= wr_tag;
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_line <= data_mem[rd_idx];
        end
    end

    assign chk_valid = valid[chk_idx];

endmodule

// File: rtl/icache_responder.sv
// 2-way blocking VIPT instruction-cache responder with line refill and uncached bypass.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
//
// state    | meaning
// IDLE     | no request outstanding, accepting
// LOOKUP   | tag compare for the request taken last cycle
// MISS_REQ | line read request pending grant
// REFILL   | receiving line beats into the victim way
// UC_REQ   | single-word uncached read pending grant
// UC_WAIT  | waiting for the uncached beat
// RESP     | returning the captured word (suppressed if cancelled)
module icache_responder
    import cpu_defs::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave fetch,
    mem_rd_if.master      mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]   perf_hit_cnt,
    output logic [31:0]   perf_miss_cnt
`endif
);

    localparam int IW    = $clog2(SETS);
    localparam int WW    = $clog2(LINE_WORDS);
    localparam int OW    = WW + 2;
    localparam int TAG_W = 32 - IW - OW;

    icache_state_t state, state_nxt;
    icache_op_t    op_in, req_op;
    logic [31:0]   req_pa;
    logic          req_cached;
    logic          victim;
    logic [WW-1:0] beat_cnt;
    logic          drop;
    logic [31:0]   resp_data;
    logic [SETS-1:0] lru;

    logic             accept, take, cancel, lookup_done, is_inv, is_hit, hit0, hit1;
    logic             beat, beat_last;
    logic [IW-1:0]    lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [WW-1:0]    lk_word;
    logic             vld0, vld1;
    logic [TAG_W-1:0] tag0, tag1;
    logic [LINE_WORDS-1:0][31:0] line0, line1;
    logic             ready;
    logic [31:0]      data;
    mem_rd_req_t      rd_req;

    assign op_in   = icache_op_t'(fetch.icache_op);
    assign cancel  = fetch.icache_cancel;
    assign lk_idx  = req_pa[IW+OW-1:OW];
    assign lk_tag  = req_pa[31:IW+OW];
    assign lk_word = req_pa[OW-1:2];

    assign hit0        = vld0 && (tag0 == lk_tag);
    assign hit1        = vld1 && (tag1 == lk_tag);
    assign is_inv      = (req_op == OP_IDX_INV);
    assign is_hit      = req_cached && (req_op == OP_FETCH) && (hit0 || hit1);
    assign lookup_done = (state == ST_LOOKUP) && (is_inv || is_hit);
    assign accept      = (state == ST_IDLE) || lookup_done || (state == ST_RESP);
    assign take        = accept && ((op_in == OP_FETCH) || (op_in == OP_IDX_INV));
    assign beat        = (state == ST_REFILL) && mem.mem_rd_valid;
    assign beat_last   = beat && mem.mem_rd_last;

    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_way0 (
        .clk(clk), .rst(rst),
        .rd_en(take), .rd_idx(fetch.icache_idx), .rd_tag(tag0), .rd_line(line0),
        .chk_idx(lk_idx), .chk_valid(vld0),
        .inv((state == ST_LOOKUP) && is_inv),
        .wr_en(beat && !victim), .wr_idx(lk_idx), .wr_word(beat_cnt),
        .wr_data(mem.mem_rd_data),
        .tag_wr(beat_last && !victim), .wr_tag(lk_tag)
    );

    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_way1 (
        .clk(clk), .rst(rst),
        .rd_en(take), .rd_idx(fetch.icache_idx), .rd_tag(tag1), .rd_line(line1),
        .chk_idx(lk_idx), .chk_valid(vld1),
        .inv((state == ST_LOOKUP) && is_inv),
        .wr_en(beat && victim), .wr_idx(lk_idx), .wr_word(beat_cnt),
        .wr_data(mem.mem_rd_data),
        .tag_wr(beat_last && victim), .wr_tag(lk_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (take) state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (lookup_done)
                    state_nxt = take ? ST_LOOKUP : ST_IDLE;
                else if (cancel)
                    state_nxt = ST_IDLE;
                else if (req_cached)
                    state_nxt = ST_MISS_REQ;
                else
                    state_nxt = ST_UC_REQ;
            end
            ST_MISS_REQ: if (mem.mem_rd_gnt) state_nxt = ST_REFILL;
            ST_REFILL:   if (beat_last) state_nxt = ST_RESP;
            ST_UC_REQ:   if (mem.mem_rd_gnt) state_nxt = ST_UC_WAIT;
            ST_UC_WAIT:  if (mem.mem_rd_valid && mem.mem_rd_last) state_nxt = ST_RESP;
            ST_RESP:     state_nxt = take ? ST_LOOKUP : ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_req = '0;
        ready  = 1'b0;
        data   = '0;
        case (state)
            ST_LOOKUP: begin
                if (is_inv) begin
                    ready = !cancel;
                end else if (is_hit) begin
                    ready = !cancel;
                    data  = hit0 ? line0[lk_word] : line1[lk_word];
                end
            end
            ST_MISS_REQ: begin
                rd_req.req  = 1'b1;
                rd_req.addr = {req_pa[31:OW], {OW{1'b0}}};
                rd_req.len  = 8'(LINE_WORDS - 1);
            end
            ST_UC_REQ: begin
                rd_req.req  = 1'b1;
                rd_req.addr = req_pa & 32'hFFFF_FFFC;
                rd_req.len  = 8'd0;
            end
            ST_RESP: begin
                ready = !drop;
                data  = resp_data;
            end
            default: ;
        endcase
    end

    assign fetch.icache_accept = accept;
    assign fetch.icache_ready  = ready;
    assign fetch.icache_data   = data;
    assign mem.mem_rd_req      = rd_req.req;
    assign mem.mem_rd_addr     = rd_req.addr;
    assign mem.mem_rd_len      = rd_req.len;

    // lru[set] names the way to evict next, i.e. the one not most recently used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pa     <= '0;
            req_cached <= 1'b0;
            req_op     <= OP_NOP;
            victim     <= 1'b0;
            beat_cnt   <= '0;
            drop       <= 1'b0;
            resp_data  <= '0;
            lru        <= '0;
        end else begin
            if (take) begin
                req_pa     <= fetch.icache_pa;
                req_cached <= fetch.icache_is_cached;
                req_op     <= op_in;
            end
            if ((state == ST_LOOKUP) && !lookup_done && !cancel && req_cached)
                victim <= !vld0 ? 1'b0 : (!vld1 ? 1'b1 : lru[lk_idx]);
            if (state == ST_MISS_REQ)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;
            if (beat && (beat_cnt == lk_word))
                resp_data <= mem.mem_rd_data;
            if ((state == ST_UC_WAIT) && mem.mem_rd_valid && mem.mem_rd_last)
                resp_data <= mem.mem_rd_data;
            if (state == ST_RESP)
                drop <= 1'b0;
            else if (cancel && ((state == ST_MISS_REQ) || (state == ST_REFILL) ||
                                (state == ST_UC_REQ) || (state == ST_UC_WAIT)))
                drop <= 1'b1;
            if ((state == ST_LOOKUP) && is_hit)
                lru[lk_idx] <= hit0;
            if (beat_last)
                lru[lk_idx] <= !victim;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if ((state == ST_LOOKUP) && !cancel && req_cached && (req_op == OP_FETCH)) begin
            if (is_hit)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            else
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized bench for icache_responder against an array-based 2-way LRU cache model
// with an inline burst-memory responder.
module tb_icache_responder;
    import cpu_defs::*;

    localparam int SETS = ICACHE_SETS;
    localparam int LW   = ICACHE_LINE_WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_fetch_if fif ();
    mem_rd_if       mif ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    icache_responder dut (
        .clk(clk), .rst(rst), .fetch(fif), .mem(mif)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory image: explicit entries, otherwise an address-derived pattern
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a))
            return mem_img[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
    endfunction

    // reference cache: per set two ways and one "evict next" bit
    bit          mv   [SETS][2];
    logic [19:0] mt   [SETS][2];
    logic [31:0] md   [SETS][2][LW];
    bit          mlru [SETS];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mv[s][0] = 0; mv[s][1] = 0; mlru[s] = 0;
        end
    endtask

    task automatic model_access(input logic [1:0] op, input logic [31:0] pa, input bit cached,
                                output bit exp_mem, output logic [31:0] exp_addr,
                                output logic [7:0] exp_len, output logic [31:0] exp_data);
        int s, w, hw, v;
        logic [19:0] t;
        s = int'(pa[11:4]);
        w = int'(pa[3:2]);
        t = pa[31:12];
        exp_mem = 0; exp_addr = '0; exp_len = '0; exp_data = '0;
        if (op == 2'd2) begin
            mv[s][0] = 0; mv[s][1] = 0;
        end else if (!cached) begin
            exp_mem  = 1;
            exp_addr = {pa[31:2], 2'b00};
            exp_data = mem_word(exp_addr);
        end else begin
            hw = -1;
            for (int k = 0; k < 2; k++)
                if (mv[s][k] && mt[s][k] == t) hw = k;
            if (hw >= 0) begin
                exp_data = md[s][hw][w];
                mlru[s]  = (hw == 0);
            end else begin
                v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(mlru[s]));
                exp_mem  = 1;
                exp_addr = {pa[31:4], 4'h0};
                exp_len  = 8'(LW - 1);
                for (int i = 0; i < LW; i++)
                    md[s][v][i] = mem_word(exp_addr + 32'(4 * i));
                mv[s][v] = 1;
                mt[s][v] = t;
                mlru[s]  = (v == 0);
                exp_data = md[s][v][w];
            end
        end
    endtask

    bit          last_saw_req;
    logic [31:0] last_data;

    // One complete transaction: issue, serve memory, observe response timing and data.
    task automatic fetch(input logic [1:0] op, input logic [31:0] pa, input bit cached,
                         input int cancel_beat);
        bit exp_mem, exp_ready, saw_req, granted, done;
        logic [31:0] exp_addr, exp_data, got_data;
        logic [7:0]  exp_len;
        int nbeats, last_cyc, rdy_cyc, gdelay;
        model_access(op, pa, cached, exp_mem, exp_addr, exp_len, exp_data);
        exp_ready = !(exp_mem && cancel_beat >= 0 && cancel_beat <= int'(exp_len));

        @(negedge clk);
        fif.icache_idx = pa[11:4];
        fif.icache_op = op;
        fif.icache_pa = pa;
        fif.icache_is_cached = cached;
        #1 check("accept_idle", {31'd0, fif.icache_accept}, 32'd1);
        @(posedge clk);
        #1 fif.icache_op = 2'd0;

        saw_req = 0; granted = 0; done = 0; nbeats = 0;
        last_cyc = -1; rdy_cyc = -1; got_data = '0;
        gdelay = int'($urandom_range(0, 2));
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mif.mem_rd_gnt = 0; mif.mem_rd_valid = 0; mif.mem_rd_last = 0;
            mif.mem_rd_data = '0; fif.icache_cancel = 0;
            if (granted && nbeats <= int'(exp_len) && $urandom_range(0, 3) != 0) begin
                mif.mem_rd_valid = 1;
                mif.mem_rd_data  = mem_word(exp_addr + 32'(4 * nbeats));
                mif.mem_rd_last  = (nbeats == int'(exp_len));
                if (nbeats == cancel_beat) fif.icache_cancel = 1;
                if (mif.mem_rd_last) last_cyc = c;
                nbeats++;
            end
            #1;
            if (mif.mem_rd_req && !granted) begin
                if (!saw_req) begin
                    check("mem_addr", mif.mem_rd_addr, exp_addr);
                    check("mem_len", {24'd0, mif.mem_rd_len}, {24'd0, exp_len});
                    saw_req = 1;
                end
                if (gdelay == 0) begin
                    mif.mem_rd_gnt = 1;
                    granted = 1;
                end else begin
                    gdelay--;
                end
            end
            if (fif.icache_ready && rdy_cyc < 0) begin
                rdy_cyc = c;
                got_data = fif.icache_data;
                done = 1;
            end
            if (granted && last_cyc >= 0 && c >= last_cyc + 2) done = 1;
        end
        mif.mem_rd_gnt = 0; mif.mem_rd_valid = 0; mif.mem_rd_last = 0;
        fif.icache_cancel = 0;

        check("mem_req_seen", {31'd0, saw_req}, {31'd0, exp_mem});
        if (exp_ready) begin
            check("ready_seen", {31'd0, rdy_cyc >= 0}, 32'd1);
            check("resp_data", got_data, exp_data);
            check("resp_latency", 32'(rdy_cyc), exp_mem ? 32'(last_cyc + 1) : 32'd0);
        end else begin
            check("cancel_no_ready", {31'd0, rdy_cyc >= 0}, 32'd0);
            check("cancel_idle_accept", {31'd0, fif.icache_accept}, 32'd1);
        end
        last_saw_req = saw_req;
        last_data    = got_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        fif.icache_idx = '0; fif.icache_op = 2'd0; fif.icache_pa = '0;
        fif.icache_is_cached = 0; fif.icache_cancel = 0;
        mif.mem_rd_gnt = 0; mif.mem_rd_valid = 0; mif.mem_rd_data = '0; mif.mem_rd_last = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, fif.icache_ready}, 32'd0);
        check("rst_data", fif.icache_data, 32'd0);
        check("rst_mem_req", {31'd0, mif.mem_rd_req}, 32'd0);
        check("rst_accept", {31'd0, fif.icache_accept}, 32'd1);
        rst = 0;

        // cold miss then hit
        mem_img[32'h1C00_0000] = 32'hA0; mem_img[32'h1C00_0004] = 32'hA1;
        mem_img[32'h1C00_0008] = 32'hA2; mem_img[32'h1C00_000C] = 32'hA3;
        fetch(2'd1, 32'h1C00_0008, 1, -1);
        check("cold_miss_data", last_data, 32'hA2);
        fetch(2'd1, 32'h1C00_000C, 1, -1);
        check("hit_data", last_data, 32'hA3);
        check("hit_no_mem", {31'd0, last_saw_req}, 32'd0);

        // uncached bypass, repeated
        mem_img[32'h1FD0_0004] = 32'h55;
        fetch(2'd1, 32'h1FD0_0004, 0, -1);
        check("uc_data", last_data, 32'h55);
        fetch(2'd1, 32'h1FD0_0004, 0, -1);
        check("uc_repeat_mem", {31'd0, last_saw_req}, 32'd1);

        // eviction of the less recently used way
        fetch(2'd1, 32'h1C00_1000, 1, -1);
        fetch(2'd1, 32'h1C00_0000, 1, -1);
        fetch(2'd1, 32'h1C00_2000, 1, -1);
        fetch(2'd1, 32'h1C00_0000, 1, -1);
        check("evict_keep_hit", {31'd0, last_saw_req}, 32'd0);
        fetch(2'd1, 32'h1C00_1000, 1, -1);
        check("evicted_miss", {31'd0, last_saw_req}, 32'd1);

        // cancel during refill: line still installed
        fetch(2'd1, 32'h1C00_3040, 1, 1);
        fetch(2'd1, 32'h1C00_3048, 1, -1);
        check("post_cancel_hit", {31'd0, last_saw_req}, 32'd0);

        // set invalidate
        fetch(2'd1, 32'h1C00_0000, 1, -1);
        fetch(2'd2, 32'h1C00_0000, 1, -1);
        check("inv_data", last_data, 32'd0);
        fetch(2'd1, 32'h1C00_0000, 1, -1);
        check("inv_then_miss", {31'd0, last_saw_req}, 32'd1);

        // randomized mix over a few sets and conflicting tags
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pa;
            int kind, cb;
            pa = {20'h1C100 + 20'($urandom_range(0, 3)), 8'($urandom_range(0, 2)),
                  2'($urandom_range(0, 3)), 2'b00};
            kind = int'($urandom_range(0, 19));
            cb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (kind < 14)      fetch(2'd1, pa, 1, cb);
            else if (kind < 17) fetch(2'd1, pa, 0, cb);
            else                fetch(2'd2, pa, 1, -1);
        end

        // reset during refill
        fetch(2'd1, 32'h1C00_0008, 1, -1);
        fetch(2'd1, 32'h1C00_0008, 1, -1);
        check("pre_rst_hit", {31'd0, last_saw_req}, 32'd0);
        @(negedge clk);
        fif.icache_idx = 8'h07; fif.icache_op = 2'd1;
        fif.icache_pa = 32'h1C00_5070; fif.icache_is_cached = 1;
        @(posedge clk);
        #1 fif.icache_op = 2'd0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (mif.mem_rd_req) begin
                seen = 1;
                mif.mem_rd_gnt = 1;
            end
        end
        check("rst_flight_req", {31'd0, seen}, 32'd1);
        @(negedge clk);
        mif.mem_rd_gnt = 0; mif.mem_rd_valid = 1;
        mif.mem_rd_data = mem_word(32'h1C00_5070); mif.mem_rd_last = 0;
        @(negedge clk);
        mif.mem_rd_valid = 0;
        rst = 1;
        #1;
        check("rst_mid_req", {31'd0, mif.mem_rd_req}, 32'd0);
        check("rst_mid_ready", {31'd0, fif.icache_ready}, 32'd0);
        check("rst_mid_accept", {31'd0, fif.icache_accept}, 32'd1);
        model_reset();
        @(negedge clk);
        rst = 0;
        fetch(2'd1, 32'h1C00_0008, 1, -1);
        check("post_rst_miss", {31'd0, last_saw_req}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
